// File: rtl/latch_array.sv
// latch_array: bank of CHANNELS independent capture latches fed from a shared
// WIDTH-bit data bus. Each channel captures under its own gate, either
// transparently (MODE=0, follows d while gate is high) or on the gate's rising
// edge (MODE=1). After a close/capture, a lockout timer ignores the gate for
// HOLD_CYCLES cycles.
//
// Ports:
//   clk       system clock, all state on rising edge
//   rst       asynchronous active-high reset
//   d         shared data bus
//   gate      per-channel gate
//   clear     per-channel synchronous clear (overrides the state machine)
//   q         held values, channel i at [i*WIDTH +: WIDTH]
//   q_b       bitwise inverse of q
//   captured  one-cycle strobe per completed capture
//   busy      high while any channel is in lockout
//
// Per-channel states:
//   state  | meaning
//   CLOSED | idle, waiting for gate
//   OPEN   | transparent, q follows d (MODE=0 only)
//   LOCK   | lockout after close/capture, gate ignored
module latch_array #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int MODE        = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          d,
  input  logic [CHANNELS-1:0]       gate,
  input  logic [CHANNELS-1:0]       clear,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS*WIDTH-1:0] q_b,
  output logic [CHANNELS-1:0]       captured,
  output logic                      busy
);

  localparam int CW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    CLOSED = 2'd0,
    OPEN   = 2'd1,
    LOCK   = 2'd2
  } state_t;

  logic [CHANNELS-1:0] lock_vec;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           st, st_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] q_r, q_nx;
    logic             cap_r, cap_nx;
    logic             gate_prev;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st        <= CLOSED;
        cnt       <= '0;
        q_r       <= '0;
        cap_r     <= 1'b0;
        gate_prev <= 1'b0;
      end else begin
        st        <= st_nx;
        cnt       <= cnt_nx;
        q_r       <= q_nx;
        cap_r     <= cap_nx;
        // Tracked in every state so a rise hidden inside lockout is consumed.
        gate_prev <= gate[i];
      end
    end

    always_comb begin
      st_nx  = st;
      cnt_nx = cnt;
      q_nx   = q_r;
      cap_nx = 1'b0;
      if (clear[i]) begin
        st_nx  = CLOSED;
        cnt_nx = '0;
        q_nx   = '0;
      end else begin
        case (st)
          CLOSED: begin
            if (MODE == 0) begin
              if (gate[i]) begin
                q_nx  = d;
                st_nx = OPEN;
              end
            end else if (gate[i] && !gate_prev) begin
              q_nx   = d;
              cap_nx = 1'b1;
              if (HOLD_CYCLES > 0) begin
                st_nx  = LOCK;
                cnt_nx = HOLD_LD;
              end
            end
          end
          OPEN: begin
            if (gate[i]) begin
              q_nx = d;
            end else begin
              cap_nx = 1'b1;
              if (HOLD_CYCLES > 0) begin
                st_nx  = LOCK;
                cnt_nx = HOLD_LD;
              end else begin
                st_nx = CLOSED;
              end
            end
          end
          LOCK: begin
            // Leaving on the count of one keeps LOCK exactly HOLD_CYCLES long.
            if (cnt <= CW'(1)) begin
              st_nx  = CLOSED;
              cnt_nx = '0;
            end else begin
              cnt_nx = cnt - CW'(1);
            end
          end
          default: begin
            st_nx  = CLOSED;
            cnt_nx = '0;
          end
        endcase
      end
    end

    assign q[i*WIDTH +: WIDTH] = q_r;
    assign captured[i]         = cap_r;
    assign lock_vec[i]         = (st == LOCK);
  end

  assign q_b  = ~q;
  assign busy = |lock_vec;

endmodule

// File: tb/tb_latch_array.sv
// Directed testbench for latch_array: three instances cover transparent mode
// with lockout, edge mode with lockout, and edge mode without lockout.
module tb_latch_array;

  logic        clk, rst;
  logic [7:0]  d;
  logic [3:0]  g0, g1, g2, c0, c1, c2;
  logic [31:0] q0, q1, q2, qb0, qb1, qb2;
  logic [3:0]  cap0, cap1, cap2;
  logic        busy0, busy1, busy2;

  int n_vec, n_miss;

  latch_array #(.WIDTH(8), .CHANNELS(4), .HOLD_CYCLES(3), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .d(d), .gate(g0), .clear(c0),
    .q(q0), .q_b(qb0), .captured(cap0), .busy(busy0));

  latch_array #(.WIDTH(8), .CHANNELS(4), .HOLD_CYCLES(3), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .d(d), .gate(g1), .clear(c1),
    .q(q1), .q_b(qb1), .captured(cap1), .busy(busy1));

  latch_array #(.WIDTH(8), .CHANNELS(4), .HOLD_CYCLES(0), .MODE(1)) dut2 (
    .clk(clk), .rst(rst), .d(d), .gate(g2), .clear(c2),
    .q(q2), .q_b(qb2), .captured(cap2), .busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    logic [7:0] vals [3];
    n_vec = 0; n_miss = 0;
    rst = 1'b1; d = '0;
    g0 = '0; g1 = '0; g2 = '0; c0 = '0; c1 = '0; c2 = '0;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---- asynchronous reset mid-lockout ----
    @(negedge clk); g0[0] = 1'b1; d = 8'hA5;
    tick();
    chk("pre_rst_q0", {24'h0, q0[7:0]}, 32'hA5);
    @(negedge clk); g0[0] = 1'b0;
    tick();
    chk("pre_rst_cap", {28'h0, cap0}, 32'h1);
    chk("pre_rst_busy", {31'h0, busy0}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_q", q0, 32'h0);
    chk("rst_qb", qb0, 32'hFFFF_FFFF);
    chk("rst_cap", {28'h0, cap0}, 32'h0);
    chk("rst_busy", {31'h0, busy0}, 32'h0);
    @(negedge clk); rst = 1'b0;

    // ---- MODE=0 transparent, channel 1 ----
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); g0[1] = 1'b1; d = vals[k];
      tick();
      chk("m0_track", {24'h0, q0[15:8]}, {24'h0, vals[k]});
    end
    @(negedge clk); g0[1] = 1'b0; d = 8'h44;
    tick();
    chk("m0_close_q", {24'h0, q0[15:8]}, 32'h33);
    chk("m0_close_cap", {28'h0, cap0}, 32'h2);
    chk("m0_close_busy", {31'h0, busy0}, 32'h1);
    @(negedge clk); g0[1] = 1'b1; d = 8'h55;
    tick();
    chk("m0_lock1_cap", {28'h0, cap0}, 32'h0);
    chk("m0_lock1_busy", {31'h0, busy0}, 32'h1);
    chk("m0_lock1_q", {24'h0, q0[15:8]}, 32'h33);
    tick();
    chk("m0_lock2_busy", {31'h0, busy0}, 32'h1);
    chk("m0_lock2_q", {24'h0, q0[15:8]}, 32'h33);
    tick();
    chk("m0_lock3_busy", {31'h0, busy0}, 32'h0);
    chk("m0_lock3_q", {24'h0, q0[15:8]}, 32'h33);
    tick();
    chk("m0_reopen_q", {24'h0, q0[15:8]}, 32'h55);
    chk("m0_reopen_cap", {28'h0, cap0}, 32'h0);
    @(negedge clk); g0[1] = 1'b0;
    tick();
    chk("m0_close2_cap", {28'h0, cap0}, 32'h2);
    chk("m0_qb", qb0, 32'hFFFF_AAFF);
    repeat (4) tick();

    // ---- MODE=1 edge capture ----
    @(negedge clk); g1[3] = 1'b1; d = 8'h77;
    tick();
    chk("m1_pre_q3", {24'h0, q1[31:24]}, 32'h77);
    @(negedge clk); g1[3] = 1'b0;
    repeat (4) tick();
    chk("m1_pre_busy", {31'h0, busy1}, 32'h0);

    @(negedge clk); g1[2] = 1'b1; d = 8'h3C;
    tick();
    chk("m1_cap_q2", {24'h0, q1[23:16]}, 32'h3C);
    chk("m1_cap_strobe", {28'h0, cap1}, 32'h4);
    pulses = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); d = 8'(8'h40 + k);
      tick();
      pulses += int'(cap1[2]);
      if (k == 0) chk("m1_busy_after", {31'h0, busy1}, 32'h1);
    end
    chk("m1_no_recap", 32'(pulses), 32'h0);
    chk("m1_hold_q2", {24'h0, q1[23:16]}, 32'h3C);
    chk("m1_idle_busy", {31'h0, busy1}, 32'h0);
    @(negedge clk); g1[2] = 1'b0;
    tick();

    // simultaneous gates on ch0/ch3, clear wins on ch3
    @(negedge clk); g1[0] = 1'b1; g1[3] = 1'b1; c1[3] = 1'b1; d = 8'h81;
    tick();
    chk("sim_q0", {24'h0, q1[7:0]}, 32'h81);
    chk("sim_q3", {24'h0, q1[31:24]}, 32'h0);
    chk("sim_cap", {28'h0, cap1}, 32'h1);

    // clear aborts lockout, fresh rise accepted right away
    @(negedge clk); g1 = '0; c1 = 4'b0001;
    tick();
    chk("clr_q0", {24'h0, q1[7:0]}, 32'h0);
    chk("clr_busy", {31'h0, busy1}, 32'h0);
    @(negedge clk); c1 = '0; g1[0] = 1'b1; d = 8'h99;
    tick();
    chk("clr_recap_q0", {24'h0, q1[7:0]}, 32'h99);
    chk("clr_recap_cap", {28'h0, cap1}, 32'h1);

    // ---- HOLD_CYCLES=0, MODE=1: capture on every rise ----
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); g2[0] = (k % 2 == 0); d = 8'(k + 1);
      tick();
      chk("h0_cap", {31'h0, cap2[0]}, (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("h0_q", {24'h0, q2[7:0]}, (k % 2 == 0) ? 32'(k + 1) : 32'(k));
      chk("h0_busy", {31'h0, busy2}, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/latch_array.md
# latch_array

Parametrised bank of synchronous capture latches replacing the single 8-bit latch. Each of CHANNELS channels holds a WIDTH-bit value taken from a shared data bus under its own gate, in either transparent (level) or edge-capture mode. After each close/capture, a per-channel lockout timer ignores the gate for HOLD_CYCLES cycles. Sits between the stimulus/data bus and downstream consumers that need stable, glitch-free held values plus a capture strobe.

## Interface
- WIDTH, 8, data width per channel (>=1)
- CHANNELS, 4, number of independent latch channels (>=1)
- HOLD_CYCLES, 3, lockout length after close/capture (0 = no lockout)
- MODE, 0, 0 = transparent (level) mode, 1 = edge-capture mode; common to all channels
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- d  in  WIDTH  shared data bus
- gate  in  CHANNELS  per-channel gate, sampled on clk
- clear  in  CHANNELS  per-channel synchronous clear
- q  out  CHANNELS*WIDTH  held values, channel i at bits [i*WIDTH +: WIDTH]
- q_b  out  CHANNELS*WIDTH  bitwise inverse of q
- captured  out  CHANNELS  one-cycle strobe per completed capture
- busy  out  1  OR of all channels in LOCK

## Operation
- Per-channel states: CLOSED, OPEN, LOCK; plus gate_prev register and lockout counter (width clog2(HOLD_CYCLES+1), min 1).
- Reset (async, rst=1): q=0, q_b=all ones, state=CLOSED, counter=0, gate_prev=0, captured=0, busy=0.
- Priority per channel per edge: clear > state machine. clear[i]=1: q=0, state=CLOSED, counter=0, captured=0; gate_prev still updates.
- MODE=0 (transparent):
  - CLOSED, gate=1: q<=d, go OPEN.
  - OPEN, gate=1: q<=d every edge.
  - OPEN, gate=0: q holds, captured<=1, go LOCK with counter=HOLD_CYCLES (or CLOSED if HOLD_CYCLES=0).
- MODE=1 (edge):
  - CLOSED, gate=1 and gate_prev=0: q<=d, captured<=1, go LOCK (or CLOSED if HOLD_CYCLES=0).
  - Gate held high does not recapture; OPEN unused.
- LOCK: gate ignored, counter decrements each edge; at counter=1 go CLOSED. LOCK lasts exactly HOLD_CYCLES cycles.
- gate_prev<=gate every edge in every state, so a rising edge that occurs during LOCK is not seen after LOCK ends unless gate falls and rises again.
- captured is 0 in every cycle not listed above.
- Channels are fully independent; simultaneous gates on several channels each capture the same d.
- q_b = ~q combinationally; busy combinational from states.

## Timing
- All inputs sampled on rising clk; q, captured, state update at that edge.
- MODE=0: q tracks d with 1-cycle latency while OPEN; captured asserts the cycle after gate is first sampled low.
- MODE=1: q and captured update together at the edge sampling the gate rise (1-cycle latency).
- Gate re-acceptance: earliest HOLD_CYCLES+1 edges after the closing/capturing edge.
- rst mid-LOCK or mid-OPEN: immediate return to reset values, no captured pulse.
- clear during LOCK aborts lockout; channel accepts gate next edge (MODE=1 requires a fresh rising edge relative to gate_prev).

## Test plan
- Reset: assert rst mid-run with q=8'hA5 on ch0 -> q=0, q_b=8'hFF all channels, captured=0, busy=0 immediately.
- MODE=0, ch1: gate high 3 cycles with d=11,22,33, then low with d=44 -> q1=33, captured[1] one cycle, busy high exactly 3 cycles.
- MODE=0 lockout: gate[1] reasserted during LOCK with d=55 -> q1 stays 33; gate high after LOCK -> q1=55.
- MODE=1, ch2: gate rises with d=8'h3C, stays high 10 cycles, d changes -> q2=8'h3C, single captured pulse, no recapture.
- Simultaneous: gate[0] and gate[3] rise same edge d=8'h81, clear[3] same edge -> q0=8'h81 captured[0]=1; q3=0 captured[3]=0.
- HOLD_CYCLES=0, MODE=1: gate toggles 0/1 every cycle with d incrementing -> capture on every rising edge, busy never high.
